// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the VGA frame-buffer reader.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam int PIX_PER_WORD            = 4;
    localparam int DEF_ADDR_W              = 14;
    localparam int DEF_WORDS_PER_FRAME     = 16000;
    localparam int DEF_FIFO_DEPTH          = 8;

endpackage

// File: rtl/vga_fb_fifo.sv
// Synchronous word FIFO with flush; DEPTH must be a power of two (>= 2).
module vga_fb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [W-1:0]           rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage is not reset; empty/valid gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PW'(push_ok);
            rptr_q  <= rptr_q + PW'(pop_ok);
            count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/vga_fb_reader.sv
// Streams one frame of 32-bit words from memory and unpacks them into 8-bit pixels.
module vga_fb_reader
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] fb_address,
    output logic              fb_chipselect,
    output logic              fb_write,
    output logic [3:0]        fb_byteenable,
    input  logic [31:0]       fb_readdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_data,
    output logic              underflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [1:0]        idx_q, idx_d;
    logic              uf_q, uf_d;

    logic [31:0]   f_rdata;
    logic          f_empty, f_full;
    logic [CW-1:0] f_count;
    logic [CW:0]   used;
    logic          credit, issue, hs, pop, push;

    // Credit counts words already buffered plus the one possibly in flight.
    assign used   = {1'b0, f_count} + (CW+1)'(pend_q);
    assign credit = !f_full && (used < (CW+1)'(FIFO_DEPTH));
    assign issue  = (state_q == ST_RUN) && !frame_start && credit;
    assign hs     = pix_valid && pix_ready && !frame_start;
    assign pop    = hs && (idx_q == 2'(PIX_PER_WORD - 1));
    assign push   = pend_q && !frame_start;

    vga_fb_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (fb_readdata),
        .pop_i   (pop),
        .flush_i (frame_start),
        .rdata_o (f_rdata),
        .empty_o (f_empty),
        .full_o  (f_full),
        .count_o (f_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = issue;
        idx_d   = idx_q;
        uf_d    = uf_q;
        if (frame_start) begin
            state_d = ST_RUN;
            addr_d  = '0;
            pend_d  = 1'b0;
            idx_d   = '0;
            uf_d    = 1'b0;
        end else begin
            if (hs) idx_d = idx_q + 2'd1;
            if (pix_ready && !pix_valid && (state_q != ST_IDLE)) uf_d = 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (issue) begin
                        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                        else                     addr_d  = addr_q + 1'b1;
                    end
                end
                // The last pixel leaves when the final word pops with nothing behind it.
                ST_DRAIN: begin
                    if (pop && (f_count == CW'(1)) && !pend_q) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            uf_q    <= uf_d;
        end
    end

    assign fb_address    = addr_q;
    assign fb_chipselect = issue;
    assign fb_write      = 1'b0;
    assign fb_byteenable = 4'hF;
    assign pix_valid     = !f_empty;
    assign pix_data      = pix_valid ? f_rdata[{idx_q, 3'b000} +: 8] : 8'h00;
    assign underflow     = uf_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench: a large-frame and a 3-word-frame reader share stimulus; a frame-level model checks both.
module tb_vga_fb_reader;
    import vga_fb_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 14;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic pix_ready = 1'b0;

    logic [AW-1:0] fb_addr [2];
    logic          cs [2];
    logic          wr [2];
    logic [3:0]    be [2];
    logic [31:0]   rd [2];
    logic          pv [2];
    logic [7:0]    pd [2];
    logic          uf [2];

    logic [31:0] mem [16];
    int          wpf [2] = '{16, 3};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_fb_reader #(.ADDR_W(AW), .WORDS_PER_FRAME(16), .FIFO_DEPTH(DEPTH)) u_big (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .fb_address(fb_addr[0]), .fb_chipselect(cs[0]), .fb_write(wr[0]),
        .fb_byteenable(be[0]), .fb_readdata(rd[0]), .pix_valid(pv[0]),
        .pix_ready(pix_ready), .pix_data(pd[0]), .underflow(uf[0]));

    vga_fb_reader #(.ADDR_W(AW), .WORDS_PER_FRAME(3), .FIFO_DEPTH(DEPTH)) u_small (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .fb_address(fb_addr[1]), .fb_chipselect(cs[1]), .fb_write(wr[1]),
        .fb_byteenable(be[1]), .fb_readdata(rd[1]), .pix_valid(pv[1]),
        .pix_ready(pix_ready), .pix_data(pd[1]), .underflow(uf[1]));

    // Memory answers one cycle after the address cycle.
    always @(posedge clk) begin
        rd[0] <= mem[fb_addr[0][3:0]];
        rd[1] <= mem[fb_addr[1][3:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: words requested, words returned, pixels accepted.
    int issued [2], recv [2], k [2];
    bit pend [2], active [2], muf [2];

    function automatic bit m_cs(int i);
        return active[i] && !frame_start && (issued[i] < wpf[i]) && ((issued[i] - k[i] / 4) < DEPTH);
    endfunction

    function automatic bit m_valid(int i);
        return recv[i] > k[i] / 4;
    endfunction

    function automatic logic [7:0] m_pix(int i);
        logic [31:0] w;
        w = mem[k[i] / 4];
        return 8'(w >> (8 * (k[i] % 4)));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                issued[i] = 0; recv[i] = 0; k[i] = 0;
                pend[i] = 0; active[i] = 0; muf[i] = 0;
            end else if (frame_start) begin
                issued[i] = 0; recv[i] = 0; k[i] = 0;
                pend[i] = 0; active[i] = 1; muf[i] = 0;
            end else begin
                bit c, v;
                c = m_cs(i);
                v = m_valid(i);
                if (pix_ready && !v && active[i]) muf[i] = 1;
                recv[i] += int'(pend[i]);
                pend[i] = c;
                issued[i] += int'(c);
                if (v && pix_ready) k[i]++;
                if (k[i] == 4 * wpf[i]) active[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "big" : "small";
            chk({p, ".fb_write"}, 32'(wr[i]), 0);
            chk({p, ".byteenable"}, 32'(be[i]), 32'hF);
            if (!reset_n) begin
                chk({p, ".rst_cs"}, 32'(cs[i]), 0);
                chk({p, ".rst_addr"}, 32'(fb_addr[i]), 0);
                chk({p, ".rst_valid"}, 32'(pv[i]), 0);
                chk({p, ".rst_data"}, 32'(pd[i]), 0);
                chk({p, ".rst_uf"}, 32'(uf[i]), 0);
            end else begin
                chk({p, ".cs"}, 32'(cs[i]), 32'(m_cs(i)));
                if (m_cs(i)) chk({p, ".addr"}, 32'(fb_addr[i]), 32'(issued[i]));
                chk({p, ".addr_range"}, 32'(fb_addr[i] <= AW'(wpf[i] - 1)), 1);
                chk({p, ".valid"}, 32'(pv[i]), 32'(m_valid(i)));
                if (m_valid(i)) chk({p, ".data"}, 32'(pd[i]), 32'(m_pix(i)));
                chk({p, ".underflow"}, 32'(uf[i]), 32'(muf[i]));
            end
        end
    end

    // Per-cycle samples and counters for the directed checks.
    logic        s_cs [2], s_valid [2], s_uf [2];
    logic [AW-1:0] s_addr [2];
    logic [7:0]  s_data [2];
    int          cs_cnt [2], hs_cnt [2], max_addr [2];
    logic [7:0]  pixlog [$];

    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_cs[i] = cs[i]; s_addr[i] = fb_addr[i]; s_valid[i] = pv[i];
            s_data[i] = pd[i]; s_uf[i] = uf[i];
            if (cs[i]) begin
                cs_cnt[i]++;
                if (int'(fb_addr[i]) > max_addr[i]) max_addr[i] = int'(fb_addr[i]);
            end
            if (pv[i] && pix_ready && !frame_start) begin
                hs_cnt[i]++;
                if (i == 0) pixlog.push_back(pd[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            cs_cnt[i] = 0; hs_cnt[i] = 0; max_addr[i] = 0;
        end
        pixlog.delete();
    endtask

    logic [7:0] exp_seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        bit got;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        for (int i = 2; i < 16; i++) mem[i] = 32'hA0B0C0D0 + 32'(i) * 32'h01010101;

        // Reset, then idle with no frame_start.
        repeat (3) cyc();
        chk("reset_cs", 32'(s_cs[0]), 0);
        chk("reset_valid", 32'(s_valid[0]), 0);
        chk("reset_uf", 32'(s_uf[0]), 0);
        reset_n = 1'b1;
        clr();
        repeat (5) cyc();
        chk("idle_no_reads", 32'(cs_cnt[0] + cs_cnt[1]), 0);

        // Unpack order, latency, starvation.
        clr();
        frame_start = 1'b1; pix_ready = 1'b1;
        cyc();
        chk("fs_cycle_cs", 32'(s_cs[0]), 0);
        frame_start = 1'b0;
        cyc();
        chk("first_read_cs", 32'(s_cs[0]), 1);
        chk("first_read_addr", 32'(s_addr[0]), 0);
        chk("valid_after_e0", 32'(s_valid[0]), 0);
        cyc();
        chk("valid_after_e1", 32'(s_valid[0]), 0);
        chk("starve_uf", 32'(s_uf[0]), 1);
        cyc();
        chk("valid_after_e2", 32'(s_valid[0]), 1);
        chk("first_pixel", 32'(s_data[0]), 32'h11);
        for (int t = 0; t < 30 && pixlog.size() < 8; t++) cyc();
        chk("pixlog_len", 32'(pixlog.size() >= 8), 1);
        for (int j = 0; j < 8 && j < pixlog.size(); j++)
            chk($sformatf("unpack[%0d]", j), 32'(pixlog[j]), 32'(exp_seq[j]));
        repeat (80) cyc();
        chk("uf_sticky_big", 32'(s_uf[0]), 1);
        chk("uf_sticky_small", 32'(s_uf[1]), 1);
        chk("frame_done_valid", 32'(s_valid[0]), 0);

        // Backpressure, then the 3-word frame end.
        frame_start = 1'b1; pix_ready = 1'b0;
        cyc();
        frame_start = 1'b0;
        clr();
        repeat (20) cyc();
        chk("bp_reads", 32'(cs_cnt[0]), 8);
        chk("bp_max_addr", 32'(max_addr[0]), 7);
        chk("bp_cs_low", 32'(s_cs[0]), 0);
        chk("bp_uf_cleared", 32'(s_uf[0]), 0);
        chk("small_reads", 32'(cs_cnt[1]), 3);
        pix_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            cyc();
            if (s_cs[0]) got = 1;
        end
        chk("bp_resume_seen", 32'(got), 1);
        chk("bp_resume_addr", 32'(s_addr[0]), 8);
        repeat (100) cyc();
        chk("small_pixels", 32'(hs_cnt[1]), 12);
        chk("small_max_addr", 32'(max_addr[1]), 2);
        chk("small_state", 32'(u_small.state_q), 32'(ST_IDLE));
        chk("small_valid", 32'(s_valid[1]), 0);
        chk("small_uf", 32'(s_uf[1]), 0);
        chk("big_pixels", 32'(hs_cnt[0]), 64);
        chk("big_uf", 32'(s_uf[0]), 0);

        // Restart while the read of word 5 is in flight.
        frame_start = 1'b1; pix_ready = 1'b0;
        cyc();
        frame_start = 1'b0; pix_ready = 1'b1;
        cyc();
        pix_ready = 1'b0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            cyc();
            if (s_cs[0] && s_addr[0] == AW'(5)) got = 1;
        end
        chk("addr5_seen", 32'(got), 1);
        chk("uf_before_restart", 32'(s_uf[0]), 1);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        chk("restart_flushed", 32'(s_valid[0]), 0);
        chk("restart_addr0", 32'(s_addr[0]), 0);
        chk("restart_uf_clear", 32'(s_uf[0]), 0);
        cyc();
        cyc();
        chk("restart_valid", 32'(s_valid[0]), 1);
        chk("restart_pixel", 32'(s_data[0]), 32'h11);
        pix_ready = 1'b1;
        repeat (100) cyc();

        // Asynchronous reset mid-frame.
        frame_start = 1'b1; pix_ready = 1'b0;
        cyc();
        frame_start = 1'b0;
        repeat (4) cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_cs", 32'(cs[0]), 0);
        chk("async_addr", 32'(fb_addr[0]), 0);
        chk("async_valid", 32'(pv[0]), 0);
        chk("async_data", 32'(pd[0]), 0);
        chk("async_uf", 32'(uf[0]), 0);
        repeat (2) cyc();
        reset_n = 1'b1;
        clr();
        repeat (10) cyc();
        chk("post_reset_no_reads", 32'(cs_cnt[0] + cs_cnt[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
